// File: rtl/debug_dump_engine.sv
// Debug dump engine: snapshots PC/cycle count on start and streams a framed,
// byte-serialised dump of PC, cycles, register file and data memory.
module debug_dump_engine #(
  parameter int NB_DATA   = 32,
  parameter int N_REGS    = 32,
  parameter int NB_REG    = 5,
  parameter int MEM_DEPTH = 128,
  parameter int NB_MADDR  = 7
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [3:0]          i_section_mask,
  input  logic                i_mem_all,
  input  logic [NB_DATA-1:0]  i_pc,
  input  logic [NB_DATA-1:0]  i_cycles,
  output logic [NB_REG-1:0]   o_reg_addr,
  input  logic [NB_DATA-1:0]  i_reg_data,
  output logic                o_mem_rd,
  output logic [NB_MADDR-1:0] o_mem_addr,
  input  logic [NB_DATA-1:0]  i_mem_data,
  input  logic                i_mem_dirty,
  output logic [7:0]          o_tx_data,
  output logic                o_tx_valid,
  input  logic                i_tx_ready,
  output logic                o_busy,
  output logic                o_done
);

  // state     | meaning
  // IDLE      | waiting for start
  // HDR/MASK  | sending 0xA5 and the captured mask byte
  // PC/CYC    | sending captured PC / cycle words
  // REG_RD/TX | register read bubble / register word transmit
  // MEM_RD    | memory read bubble (next address already on the bus)
  // MEM_CHK   | examine data+dirty; clean words skip one per cycle
  // MEM_TXA/D | memory entry address word / data word
  // TRL/CNT   | trailer 0x5A and 16-bit entry count
  // DONE      | one-cycle completion pulse

  localparam int NBYTES  = NB_DATA / 8;
  localparam int NB_BCNT = $clog2(NBYTES) + 1;
  localparam int NB_SH   = (NB_DATA < 16) ? 16 : NB_DATA;

  localparam logic [NB_BCNT-1:0]  WORD_LAST = NB_BCNT'(NBYTES - 1);
  localparam logic [NB_REG-1:0]   REG_LAST  = NB_REG'(N_REGS - 1);
  localparam logic [NB_MADDR-1:0] MEM_LAST  = NB_MADDR'(MEM_DEPTH - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_MASK, S_PC, S_CYC, S_REG_RD, S_REG_TX,
    S_MEM_RD, S_MEM_CHK, S_MEM_TXA, S_MEM_TXD, S_TRL, S_CNT, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          mask_q, mask_d;
  logic                mem_all_q, mem_all_d;
  logic [NB_DATA-1:0]  pc_q, pc_d;
  logic [NB_DATA-1:0]  cyc_q, cyc_d;
  logic [NB_SH-1:0]    shift_q, shift_d;
  logic [NB_BCNT-1:0]  byte_cnt_q, byte_cnt_d;
  logic [NB_REG-1:0]   reg_addr_q, reg_addr_d;
  logic                reg_last_q, reg_last_d;
  logic [NB_MADDR-1:0] mem_addr_q, mem_addr_d;
  logic [NB_MADDR-1:0] chk_addr_q, chk_addr_d;
  logic [NB_DATA-1:0]  mem_data_q, mem_data_d;
  logic [15:0]         ent_cnt_q, ent_cnt_d;

  logic               tx_valid;
  logic               accept;
  logic               word_done;
  logic [NB_BCNT-1:0] last_idx;

  // First enabled section at or after position 'from' (0 PC, 1 CYC, 2 REG, 3 MEM).
  function automatic state_t next_section(input logic [3:0] m, input int from);
    if (from <= 0 && m[0]) return S_PC;
    if (from <= 1 && m[1]) return S_CYC;
    if (from <= 2 && m[2]) return S_REG_RD;
    if (from <= 3 && m[3]) return S_MEM_RD;
    return S_TRL;
  endfunction

  function automatic logic [NB_MADDR-1:0] mem_next(input logic [NB_MADDR-1:0] a);
    return (a == MEM_LAST) ? '0 : a + NB_MADDR'(1);
  endfunction

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    mem_all_d  = mem_all_q;
    pc_d       = pc_q;
    cyc_d      = cyc_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    reg_addr_d = reg_addr_q;
    reg_last_d = reg_last_q;
    mem_addr_d = mem_addr_q;
    chk_addr_d = chk_addr_q;
    mem_data_d = mem_data_q;
    ent_cnt_d  = ent_cnt_q;

    last_idx = WORD_LAST;
    case (state_q)
      S_HDR, S_MASK, S_TRL: last_idx = '0;
      S_CNT:                last_idx = NB_BCNT'(1);
      default:              ;
    endcase

    tx_valid  = state_q inside {S_HDR, S_MASK, S_PC, S_CYC, S_REG_TX,
                                S_MEM_TXA, S_MEM_TXD, S_TRL, S_CNT};
    accept    = tx_valid && i_tx_ready;
    word_done = accept && (byte_cnt_q == last_idx);

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d   = S_HDR;
          mask_d    = i_section_mask;
          mem_all_d = i_mem_all;
          pc_d      = i_pc;
          cyc_d     = i_cycles;
          ent_cnt_d = '0;
        end
      end
      S_HDR:  if (word_done) state_d = S_MASK;
      S_MASK: if (word_done) state_d = next_section(mask_q, 0);
      S_PC:   if (word_done) state_d = next_section(mask_q, 1);
      S_CYC:  if (word_done) state_d = next_section(mask_q, 2);
      S_REG_RD: begin
        // Address advances as the word is captured so the next read has a
        // full cycle of settled address before its own REG_RD.
        state_d = S_REG_TX;
        if (reg_addr_q == REG_LAST) begin
          reg_addr_d = '0;
          reg_last_d = 1'b1;
        end else begin
          reg_addr_d = reg_addr_q + NB_REG'(1);
        end
      end
      S_REG_TX: begin
        if (word_done) begin
          if (reg_last_q) begin
            reg_last_d = 1'b0;
            state_d    = next_section(mask_q, 3);
          end else begin
            state_d = S_REG_RD;
          end
        end
      end
      S_MEM_RD: begin
        state_d    = S_MEM_CHK;
        chk_addr_d = mem_addr_q;
        mem_addr_d = mem_next(mem_addr_q);
      end
      S_MEM_CHK: begin
        if (mem_all_q || i_mem_dirty) begin
          state_d    = S_MEM_TXA;
          mem_data_d = i_mem_data;
          if (ent_cnt_q != 16'hFFFF) ent_cnt_d = ent_cnt_q + 16'd1;
        end else if (chk_addr_q == MEM_LAST) begin
          state_d    = S_TRL;
          mem_addr_d = '0;
          chk_addr_d = '0;
        end else begin
          chk_addr_d = mem_addr_q;
          mem_addr_d = mem_next(mem_addr_q);
        end
      end
      S_MEM_TXA: if (word_done) state_d = S_MEM_TXD;
      S_MEM_TXD: begin
        if (word_done) begin
          if (chk_addr_q == MEM_LAST) begin
            state_d    = S_TRL;
            mem_addr_d = '0;
            chk_addr_d = '0;
          end else begin
            state_d = S_MEM_RD;
          end
        end
      end
      S_TRL:  if (word_done) state_d = S_CNT;
      S_CNT:  if (word_done) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Every transmitting state is entered with its word already loaded.
    if (state_d != state_q) begin
      byte_cnt_d = '0;
      case (state_d)
        S_HDR:     shift_d = NB_SH'(8'hA5);
        S_MASK:    shift_d = NB_SH'({4'h0, mask_q});
        S_PC:      shift_d = NB_SH'(pc_q);
        S_CYC:     shift_d = NB_SH'(cyc_q);
        S_REG_TX:  shift_d = NB_SH'(i_reg_data);
        S_MEM_TXA: shift_d = NB_SH'(chk_addr_q);
        S_MEM_TXD: shift_d = NB_SH'(mem_data_q);
        S_TRL:     shift_d = NB_SH'(8'h5A);
        S_CNT:     shift_d = NB_SH'(ent_cnt_q);
        default:   ;
      endcase
    end else if (accept) begin
      shift_d    = shift_q >> 8;
      byte_cnt_d = byte_cnt_q + NB_BCNT'(1);
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      mask_q     <= '0;
      mem_all_q  <= 1'b0;
      pc_q       <= '0;
      cyc_q      <= '0;
      shift_q    <= '0;
      byte_cnt_q <= '0;
      reg_addr_q <= '0;
      reg_last_q <= 1'b0;
      mem_addr_q <= '0;
      chk_addr_q <= '0;
      mem_data_q <= '0;
      ent_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      mem_all_q  <= mem_all_d;
      pc_q       <= pc_d;
      cyc_q      <= cyc_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      reg_addr_q <= reg_addr_d;
      reg_last_q <= reg_last_d;
      mem_addr_q <= mem_addr_d;
      chk_addr_q <= chk_addr_d;
      mem_data_q <= mem_data_d;
      ent_cnt_q  <= ent_cnt_d;
    end
  end

  assign o_tx_valid = tx_valid;
  assign o_tx_data  = shift_q[7:0];
  assign o_busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign o_done     = (state_q == S_DONE);
  assign o_mem_rd   = state_q inside {S_MEM_RD, S_MEM_CHK, S_MEM_TXA, S_MEM_TXD};
  assign o_reg_addr = reg_addr_q;
  assign o_mem_addr = mem_addr_q;

endmodule

// File: tb/tb_debug_dump_engine.sv
// Bench for debug_dump_engine: vector table of frames checked against a
// frame-level reference model, plus reset and restart sequences.
module tb_debug_dump_engine;

  localparam int NB_DATA   = 32;
  localparam int N_REGS    = 32;
  localparam int NB_REG    = 5;
  localparam int MEM_DEPTH = 128;
  localparam int NB_MADDR  = 7;
  localparam int BUDGET    = 20000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [3:0] sec_mask = '0;
  logic mem_all = 1'b0;
  logic [NB_DATA-1:0] pc = '0;
  logic [NB_DATA-1:0] cycles = '0;
  logic [NB_REG-1:0] reg_addr;
  logic [NB_DATA-1:0] reg_data = '0;
  logic mem_rd;
  logic [NB_MADDR-1:0] mem_addr;
  logic [NB_DATA-1:0] mem_data = '0;
  logic mem_dirty = 1'b0;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready = 1'b1;
  logic busy;
  logic done;

  always #5 clk = ~clk;

  debug_dump_engine #(
    .NB_DATA(NB_DATA), .N_REGS(N_REGS), .NB_REG(NB_REG),
    .MEM_DEPTH(MEM_DEPTH), .NB_MADDR(NB_MADDR)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start),
    .i_section_mask(sec_mask), .i_mem_all(mem_all),
    .i_pc(pc), .i_cycles(cycles),
    .o_reg_addr(reg_addr), .i_reg_data(reg_data),
    .o_mem_rd(mem_rd), .o_mem_addr(mem_addr),
    .i_mem_data(mem_data), .i_mem_dirty(mem_dirty),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
    .o_busy(busy), .o_done(done)
  );

  logic [NB_DATA-1:0] regfile [N_REGS];
  logic [NB_DATA-1:0] mem_arr [MEM_DEPTH];
  bit                 dirty_arr [MEM_DEPTH];

  // Synchronous-read register file and memory.
  always @(posedge clk) begin
    reg_data  <= regfile[reg_addr];
    mem_data  <= mem_arr[mem_addr];
    mem_dirty <= dirty_arr[mem_addr];
  end

  // Byte monitor, sampled half a cycle before the transferring edge.
  logic [7:0] got_q [$];
  int  done_total = 0;
  int  stall_total = 0;
  bit  stalled = 1'b0;
  logic [7:0] stall_data = '0;

  always @(negedge clk) begin
    if (tx_valid && tx_ready && !rst) got_q.push_back(tx_data);
    if (done) done_total <= done_total + 1;
    if (stalled && tx_valid && tx_data !== stall_data) stall_total <= stall_total + 1;
    stalled    <= tx_valid && !tx_ready;
    stall_data <= tx_data;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_stream(input string name, input logic [7:0] ref_q [$]);
    int mism;
    int first;
    mism  = 0;
    first = -1;
    chk({name, "_len"}, 64'(got_q.size()), 64'(ref_q.size()));
    for (int k = 0; k < ref_q.size(); k++) begin
      if (k >= got_q.size() || got_q[k] !== ref_q[k]) begin
        mism++;
        if (first < 0) first = k;
      end
    end
    if (mism != 0) $display("note: %s first differing byte at index %0d", name, first);
    chk({name, "_bytes"}, 64'(mism), 64'd0);
  endtask

  // Frame-level reference model built straight from the framing rules.
  logic [7:0] exp_q [$];

  function automatic void push_word(input logic [NB_DATA-1:0] w);
    for (int b = 0; b < NB_DATA / 8; b++) exp_q.push_back(w[8*b +: 8]);
  endfunction

  function automatic void build_exp(input logic [3:0] m, input bit all,
                                    input logic [NB_DATA-1:0] p,
                                    input logic [NB_DATA-1:0] c);
    int cnt;
    cnt = 0;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back({4'h0, m});
    if (m[0]) push_word(p);
    if (m[1]) push_word(c);
    if (m[2]) for (int r = 0; r < N_REGS; r++) push_word(regfile[r]);
    if (m[3]) begin
      for (int a = 0; a < MEM_DEPTH; a++) begin
        if (all || dirty_arr[a]) begin
          push_word(NB_DATA'(a));
          push_word(mem_arr[a]);
          cnt++;
        end
      end
    end
    if (cnt > 65535) cnt = 65535;
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'(cnt));
    exp_q.push_back(8'(cnt >> 8));
  endfunction

  function automatic void setup_mem(input int pat);
    for (int a = 0; a < MEM_DEPTH; a++) begin
      mem_arr[a]   = $urandom;
      dirty_arr[a] = (pat == 1) ? ($urandom_range(3) == 0) : 1'b0;
    end
    if (pat == 0) begin
      mem_arr[5]     = 32'hDEADBEEF;
      dirty_arr[5]   = 1'b1;
      mem_arr[127]   = 32'h12345678;
      dirty_arr[127] = 1'b1;
    end
  endfunction

  typedef struct {
    logic [3:0]         mask;
    bit                 mem_all;
    logic [NB_DATA-1:0] pc;
    logic [NB_DATA-1:0] cyc;
    int                 ready_pct;
    int                 mem_pat;
    int                 exp_len;
    bit                 repulse;
  } vec_t;

  vec_t vecs [7];

  task automatic run_frame(input vec_t v, input string name);
    int d0;
    int s0;
    int cyc;
    got_q.delete();
    d0 = done_total;
    s0 = stall_total;
    @(posedge clk); #1;
    start    = 1'b1;
    sec_mask = v.mask;
    mem_all  = v.mem_all;
    pc       = v.pc;
    cycles   = v.cyc;
    tx_ready = ($urandom_range(99) >= v.ready_pct);
    @(posedge clk); #1;
    chk({name, "_start"}, {busy, tx_valid, tx_data}, {1'b1, 1'b1, 8'hA5});
    start    = v.repulse;
    sec_mask = 4'($urandom);
    mem_all  = 1'($urandom);
    pc       = $urandom;
    cycles   = $urandom;
    cyc = 0;
    while (done_total == d0 && cyc < BUDGET) begin
      tx_ready = ($urandom_range(99) >= v.ready_pct);
      if (v.repulse) start = busy || done;
      @(posedge clk); #1;
      cyc++;
    end
    start    = 1'b0;
    tx_ready = 1'b1;
    if (cyc >= BUDGET) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: no o_done within %0d cycles", name, BUDGET);
    end
    repeat (20) @(posedge clk);
    #1;
    cmp_stream(name, exp_q);
    if (v.exp_len >= 0) chk({name, "_planlen"}, 64'(got_q.size()), 64'(v.exp_len));
    chk({name, "_done_cnt"}, 64'(done_total - d0), 64'd1);
    chk({name, "_stall_stable"}, 64'(stall_total - s0), 64'd0);
    chk({name, "_idle_after"}, {busy, tx_valid, done}, 3'b000);
  endtask

  logic [7:0] lit_q [$];

  initial begin
    vecs[0] = '{4'h3, 1'b0, 32'h10, 32'h2A, 0, 0, 13, 1'b0};
    vecs[1] = '{4'h4, 1'b0, 32'h0, 32'h0, 0, 0, 133, 1'b0};
    vecs[2] = '{4'h8, 1'b0, 32'h0, 32'h0, 0, 0, 21, 1'b0};
    vecs[3] = '{4'h3, 1'b0, 32'h10, 32'h2A, 30, 0, 13, 1'b0};
    vecs[4] = '{4'h0, 1'b0, 32'h0, 32'h0, 0, 0, 5, 1'b1};
    vecs[5] = '{4'hF, 1'b1, 32'h8000_1234, 32'hCAFE_F00D, 30, 1, 1165, 1'b0};
    vecs[6] = '{4'hC, 1'b0, 32'h0, 32'h0, 20, 1, -1, 1'b0};

    for (int r = 0; r < N_REGS; r++) regfile[r] = NB_DATA'(r) * 32'h01010101;
    setup_mem(0);

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_values", {tx_valid, tx_data, busy, done, mem_rd, reg_addr, mem_addr}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      setup_mem(vecs[i].mem_pat);
      build_exp(vecs[i].mask, vecs[i].mem_all, vecs[i].pc, vecs[i].cyc);
      run_frame(vecs[i], $sformatf("vec%0d", i));
      if (i == 0 || i == 3) begin
        lit_q = '{8'hA5, 8'h03, 8'h10, 8'h00, 8'h00, 8'h00, 8'h2A,
                  8'h00, 8'h00, 8'h00, 8'h5A, 8'h00, 8'h00};
        cmp_stream($sformatf("lit%0d", i), lit_q);
      end
      if (i == 2) begin
        lit_q = '{8'hA5, 8'h08, 8'h05, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE,
                  8'hAD, 8'hDE, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56,
                  8'h34, 8'h12, 8'h5A, 8'h02, 8'h00};
        cmp_stream("lit2", lit_q);
      end
      if (i == 1 && got_q.size() == 133) begin
        chk("reg10_bytes", {got_q[42], got_q[43], got_q[44], got_q[45]}, 32'h0A0A0A0A);
        chk("reg_trailer", {got_q[130], got_q[131], got_q[132]}, 24'h5A0000);
      end
    end

    // Reset in the middle of register 10's transmission.
    begin
      int cyc;
      setup_mem(0);
      @(posedge clk); #1;
      start    = 1'b1;
      sec_mask = 4'h4;
      tx_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0;
      while (reg_addr != 5'd11 && cyc < 1000) begin
        @(posedge clk); #1;
        cyc++;
      end
      chk("rst_reached_reg10", 64'(cyc < 1000), 64'd1);
      chk("rst_pre_busy", {busy, tx_valid}, 2'b11);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_outputs", {tx_valid, tx_data, busy, done, mem_rd, reg_addr, mem_addr}, 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_no_resume", {busy, tx_valid}, 2'b00);
      build_exp(vecs[0].mask, vecs[0].mem_all, vecs[0].pc, vecs[0].cyc);
      run_frame(vecs[0], "after_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
